// File: rtl/divider_4bit_seq.sv
// divider_4bit_seq: sequential restoring divider for unsigned operands.
// One quotient bit is produced per clock, MSB first, behind a start/busy/done handshake.
// Optional feature macro: DIV_ZERO_CHECK_EN. When defined, a zero divisor short-circuits
// straight to DONE with div_by_zero=1. When undefined, a zero divisor iterates normally
// and div_by_zero stays 0.
module divider_4bit_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned    CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;        // dividend shifter; fills with quotient bits
  logic [WIDTH-1:0] v_q, v_d;        // captured divisor
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder (always < divisor between steps)
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] r_sub;
  logic             fits;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  // r_shift < 2*divisor, so the WIDTH-bit difference is exact whenever fits is set.
  always_comb begin
    r_shift = {r_q, d_q[WIDTH-1]};
    fits    = (r_shift >= {1'b0, v_q});
    r_sub   = r_shift[WIDTH-1:0] - v_q;
  end

  // Next-state and datapath updates; results only move on entry to DONE.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          d_d     = dividend;
          v_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        d_d   = {d_q[WIDTH-2:0], fits};
        r_d   = fits ? r_sub : r_shift[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          quot_d  = {d_q[WIDTH-2:0], fits};
          rem_d   = fits ? r_sub : r_shift[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any divide in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb_divider_4bit_seq: randomized and directed checking of divider_4bit_seq against a
// cycle-level arithmetic reference model, plus literal expectations for the named cases.
module tb_divider_4bit_seq;

  localparam int unsigned W = 4;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  always #5 clk = ~clk;

  divider_4bit_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference arithmetic
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return a;
    return a % b;
  endfunction

  // Cycle model: a busy countdown, a pending result, and the published result.
  int           m_cnt;
  logic         m_done, m_dbz;
  logic [W-1:0] m_q, m_r, p_q, p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      p_q    <= '0;
      p_r    <= '0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_q   <= p_q;
        m_r   <= p_r;
        m_dbz <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (DZ && divisor == '0) begin
          m_done <= 1'b1;
          m_q    <= '1;
          m_r    <= dividend;
          m_dbz  <= 1'b1;
        end else begin
          m_cnt <= int'(W);
          p_q   <= ref_q(dividend, divisor);
          p_r   <= ref_r(dividend, divisor);
        end
      end
    end
  end

  // Literal expectations armed by the stimulus for named cases
  int           lit_id = 0, lit_seen = 0, lit_acc = 0, lit_lat = 0;
  logic [W-1:0] lit_q = '0, lit_r = '0;
  logic         lit_dbz = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  // Single compare process, sampling on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quot", int'(quotient), 0);
      chk("rst_rem",  int'(remainder), 0);
      chk("rst_dbz",  int'(div_by_zero), 0);
    end else begin
      chk("busy", int'(busy), int'(m_cnt != 0));
      chk("done", int'(done), int'(m_done));
      chk("quot", int'(quotient), int'(m_q));
      chk("rem",  int'(remainder), int'(m_r));
      chk("dbz",  int'(div_by_zero), int'(m_dbz));
      if (done && lit_id != lit_seen) begin
        lit_seen = lit_id;
        chk("lit_quot", int'(quotient), int'(lit_q));
        chk("lit_rem",  int'(remainder), int'(lit_r));
        chk("lit_dbz",  int'(div_by_zero), int'(lit_dbz));
        chk("lit_latency", cyc - lit_acc, lit_lat);
      end
    end
  end

  task automatic drive(input bit sync, input logic [W-1:0] a, input logic [W-1:0] b);
    if (sync) @(negedge clk);
    #2;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue_lit(input bit sync, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r);
    if (sync) @(negedge clk);
    #2;
    lit_q   = q;
    lit_r   = r;
    lit_dbz = DZ && (b == '0);
    lit_lat = (DZ && b == '0) ? 1 : int'(W) + 1;
    lit_acc = cyc;
    lit_id++;
    drive(1'b0, a, b);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) break;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic divide with literal latency and result
    issue_lit(1'b1, 4'd13, 4'd3, 4'd4, 4'd1);
    wait_done();

    // Reset in the middle of a run: abort, no done afterwards
    drive(1'b1, 4'd13, 4'd3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Corners
    issue_lit(1'b1, 4'd15, 4'd1,  4'd15, 4'd0); wait_done();
    issue_lit(1'b1, 4'd7,  4'd9,  4'd0,  4'd7); wait_done();
    issue_lit(1'b1, 4'd15, 4'd15, 4'd1,  4'd0); wait_done();
    issue_lit(1'b1, 4'd0,  4'd5,  4'd0,  4'd0); wait_done();
    issue_lit(1'b1, 4'd9,  4'd0,  4'd15, 4'd9); wait_done();

    // Start during RUN is ignored; then back-to-back start in the DONE cycle
    issue_lit(1'b1, 4'd12, 4'd5, 4'd2, 4'd2);
    @(negedge clk);
    #2 start = 1'b1; dividend = 4'd10; divisor = 4'd3;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    issue_lit(1'b0, 4'd10, 4'd3, 4'd3, 4'd1);
    wait_done();

    // Exhaustive operand pairs, mixing back-to-back and idle gaps
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(($urandom_range(0, 1) == 0), W'(a), W'(b));
        wait_done();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    // Random start traffic, including starts ignored during RUN
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #2;
      start    = ($urandom_range(0, 3) == 0);
      dividend = W'($urandom);
      divisor  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
    end

    // Start held high: re-accepted each DONE cycle
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      start    = 1'b1;
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end
    @(negedge clk);
    #2 start = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
